mipi_rx_line_unpack: RTL and testbench

//  Receive side of the MIPI pixel path. Accepts 64-bit packed words {Y0,80h,Y1,80h,Y2,80h,Y3,80h} (Y0 in [63:56]) on MRCK.

---
 rtl/mipi_rx_line_unpack.sv | 211 +++++++++++++++++++++
 tb/tb_mipi_rx_line_unpack.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/mipi_rx_line_unpack.sv
// MIPI RX line unpacker: MRCK-side writer into a two-line ping-pong RAM, PCK-side frame-locked
// H/V timing replay as a 10-bit pixel stream. Define MRX_ERR_EN for sticky overflow/count errors.
module mipi_rx_line_unpack #(
  parameter int unsigned MAX_WORDS = 480,
  parameter int unsigned AW        = 9
) (
  input  logic        MRCK,
  input  logic        PCK,
  input  logic        RSTN,
  input  logic        iMRX_VSYNC,
  input  logic        iMRX_HSYNC,
  input  logic        iMRX_VALID,
  input  logic [63:0] iMRX_DATA,
  input  logic [10:0] MRX_HTW,
  input  logic [10:0] MRX_VTW,
  input  logic [10:0] MRX_HSP,
  input  logic [10:0] MRX_VSP,
  input  logic [10:0] MRX_HW,
  input  logic [10:0] MRX_VW,
  input  logic        MRX_ON,
  input  logic        ERR_CLR,
  output logic [9:0]  DO,
  output logic        DO_HLOCK,
  output logic        DO_VLOCK,
  output logic        DO_ACT,
  output logic [1:0]  oERR
);

  // Bank 1 lives at offset MAX_WORDS so the RAM is exactly 2*MAX_WORDS deep.
  localparam logic [AW:0]   BankOfs  = (AW+1)'(MAX_WORDS);
  localparam logic [AW-1:0] LastAddr = AW'(MAX_WORDS - 1);

  logic [63:0] mem [2*MAX_WORDS];

  // ---------------- MRCK write side ----------------
  logic          vs_q, valid_q, wbank_q, wfull_q, flag_mrck_q;
  logic [AW-1:0] waddr_q;
  logic          vs_rise, valid_fall, wr_en;
  logic [AW:0]   wr_lin;

  assign vs_rise    = iMRX_VSYNC & ~vs_q;
  assign valid_fall = valid_q & ~iMRX_VALID;
  assign wr_en      = iMRX_VALID & (vs_rise | ~wfull_q);
  assign wr_lin     = vs_rise ? '0 :
                      (wbank_q ? BankOfs + {1'b0, waddr_q} : {1'b0, waddr_q});

  always_ff @(posedge MRCK or negedge RSTN) begin
    if (!RSTN) begin
      vs_q        <= 1'b0;
      valid_q     <= 1'b0;
      wbank_q     <= 1'b0;
      wfull_q     <= 1'b0;
      flag_mrck_q <= 1'b0;
      waddr_q     <= '0;
    end else begin
      vs_q    <= iMRX_VSYNC;
      valid_q <= iMRX_VALID;
      if (vs_rise) begin
        flag_mrck_q <= ~flag_mrck_q;
        wbank_q     <= 1'b0;
        wfull_q     <= 1'b0;
        waddr_q     <= iMRX_VALID ? AW'(1) : '0;
      end else if (valid_fall) begin
        wbank_q <= ~wbank_q;
        wfull_q <= 1'b0;
        waddr_q <= '0;
      end else if (iMRX_VALID && !wfull_q) begin
        if (waddr_q == LastAddr) wfull_q <= 1'b1;
        else                     waddr_q <= waddr_q + AW'(1);
      end
    end
  end

  always_ff @(posedge MRCK) begin
    if (wr_en) mem[wr_lin] <= iMRX_DATA;
  end

  // ---------------- PCK frame lock and timing ----------------
  logic [2:0]  flag_sync_q;
  logic        frm_re;
  logic [10:0] hcnt_q, vcnt_q;
  logic [11:0] h_end, v_end;
  logic        act, rbank;
  logic [1:0]  phase;
  logic [AW-1:0] raddr_q;
  logic [AW:0]   rd_lin;

  assign frm_re = flag_sync_q[1] ^ flag_sync_q[2];
  assign h_end  = {1'b0, MRX_HSP} + {1'b0, MRX_HW};
  assign v_end  = {1'b0, MRX_VSP} + {1'b0, MRX_VW};
  assign act    = (hcnt_q >= MRX_HSP) && ({1'b0, hcnt_q} < h_end) &&
                  (vcnt_q >= MRX_VSP) && ({1'b0, vcnt_q} < v_end);
  assign rbank  = vcnt_q[0] ^ MRX_VSP[0];
  assign phase  = hcnt_q[1:0] - MRX_HSP[1:0];
  assign rd_lin = rbank ? BankOfs + {1'b0, raddr_q} : {1'b0, raddr_q};

  always_ff @(posedge PCK or negedge RSTN) begin
    if (!RSTN) begin
      flag_sync_q <= '0;
      hcnt_q      <= '0;
      vcnt_q      <= '0;
      raddr_q     <= '0;
    end else begin
      flag_sync_q <= {flag_sync_q[1:0], flag_mrck_q};
      if (frm_re) begin
        hcnt_q <= '0;
        vcnt_q <= '0;
      end else if (hcnt_q == MRX_HTW - 11'd1) begin
        hcnt_q <= '0;
        vcnt_q <= (vcnt_q == MRX_VTW - 11'd1) ? '0 : vcnt_q + 11'd1;
      end else begin
        hcnt_q <= hcnt_q + 11'd1;
      end
      if (!act)               raddr_q <= '0;
      else if (phase == 2'd0) raddr_q <= raddr_q + AW'(1);
    end
  end

  // ---------------- Read pipeline and outputs ----------------
  logic [63:0] rdata_q;
  logic        act_d1_q, hl_d1_q, vl_d1_q;
  logic [1:0]  ph_d1_q;
  logic [7:0]  ysel;

  always_ff @(posedge PCK) begin
    if (act && phase == 2'd0) rdata_q <= mem[rd_lin];
  end

  always_comb begin
    ysel = 8'h00;
    case (ph_d1_q)
      2'd0:    ysel = rdata_q[63:56];
      2'd1:    ysel = rdata_q[47:40];
      2'd2:    ysel = rdata_q[31:24];
      default: ysel = rdata_q[15:8];
    endcase
  end

  always_ff @(posedge PCK or negedge RSTN) begin
    if (!RSTN) begin
      act_d1_q <= 1'b0;
      hl_d1_q  <= 1'b0;
      vl_d1_q  <= 1'b0;
      ph_d1_q  <= '0;
      DO       <= '0;
      DO_ACT   <= 1'b0;
      DO_HLOCK <= 1'b0;
      DO_VLOCK <= 1'b0;
    end else begin
      act_d1_q <= act;
      ph_d1_q  <= phase;
      hl_d1_q  <= (hcnt_q == 11'd0);
      vl_d1_q  <= (hcnt_q == 11'd0) && (vcnt_q == 11'd0);
      DO       <= (MRX_ON && act_d1_q) ? {ysel, 2'b00} : 10'd0;
      DO_ACT   <= MRX_ON & act_d1_q;
      DO_HLOCK <= MRX_ON & hl_d1_q;
      DO_VLOCK <= MRX_ON & vl_d1_q;
    end
  end

`ifdef MRX_ERR_EN
  // Events toggle in MRCK; each toggle becomes a one-shot set of the sticky PCK bit.
  logic [1:0]  err_tgl_q, err_s1_q, err_s2_q, err_s3_q, err_q;
  logic        ovf_line_q, ovf_ev, mis_ev;
  logic [10:0] hw_words;

  assign hw_words = {2'b00, MRX_HW[10:2]};
  assign ovf_ev   = iMRX_VALID & ~vs_rise & wfull_q;
  assign mis_ev   = valid_fall & ~vs_rise &
                    (wfull_q ? (ovf_line_q || 11'(MAX_WORDS) != hw_words)
                             : (11'(waddr_q) != hw_words));

  always_ff @(posedge MRCK or negedge RSTN) begin
    if (!RSTN) begin
      err_tgl_q  <= '0;
      ovf_line_q <= 1'b0;
    end else begin
      err_tgl_q <= err_tgl_q ^ {ovf_ev, mis_ev};
      if (vs_rise || valid_fall) ovf_line_q <= 1'b0;
      else if (ovf_ev)           ovf_line_q <= 1'b1;
    end
  end

  always_ff @(posedge PCK or negedge RSTN) begin
    if (!RSTN) begin
      err_s1_q <= '0;
      err_s2_q <= '0;
      err_s3_q <= '0;
      err_q    <= '0;
    end else begin
      err_s1_q <= err_tgl_q;
      err_s2_q <= err_s1_q;
      err_s3_q <= err_s2_q;
      err_q    <= ERR_CLR ? 2'b00 : (err_q | (err_s2_q ^ err_s3_q));
    end
  end

  assign oERR = err_q;

  logic unused_bits;
  assign unused_bits = ^{iMRX_HSYNC, rdata_q[55:48], rdata_q[39:32], rdata_q[23:16],
                         rdata_q[7:0]};
`else
  assign oERR = 2'b00;

  logic unused_bits;
  assign unused_bits = ^{iMRX_HSYNC, ERR_CLR, rdata_q[55:48], rdata_q[39:32],
                         rdata_q[23:16], rdata_q[7:0]};
`endif

endmodule

// File: tb/tb_mipi_rx_line_unpack.sv
// Scoreboard bench for mipi_rx_line_unpack: random frames are pushed as expected pixel streams
// and a PCK monitor pops and compares on every DO_ACT cycle.
`timescale 1ns/1ps
module tb_mipi_rx_line_unpack;

  localparam int MaxW = 480;
  localparam int Hw = 16, Vw = 4, Hsp = 8, Vsp = 3, Htw = 40, Vtw = 10;

  logic        mrck = 1'b0, pck = 1'b0, rstn = 1'b0;
  logic        vsync = 1'b0, hsync = 1'b0, valid = 1'b0;
  logic [63:0] data = '0;
  logic        on = 1'b0, err_clr = 1'b0;
  logic [9:0]  do_px;
  logic        hlock, vlock, act_o;
  logic [1:0]  oerr;

  int checks = 0, errors = 0;
  int mcyc = 0;
  logic [9:0] exp_q[$];

  always #2 mrck = ~mrck;
  always #5 pck = ~pck;
  always @(posedge mrck) mcyc <= mcyc + 1;

  mipi_rx_line_unpack dut (
    .MRCK      (mrck),
    .PCK       (pck),
    .RSTN      (rstn),
    .iMRX_VSYNC(vsync),
    .iMRX_HSYNC(hsync),
    .iMRX_VALID(valid),
    .iMRX_DATA (data),
    .MRX_HTW   (11'(Htw)),
    .MRX_VTW   (11'(Vtw)),
    .MRX_HSP   (11'(Hsp)),
    .MRX_VSP   (11'(Vsp)),
    .MRX_HW    (11'(Hw)),
    .MRX_VW    (11'(Vw)),
    .MRX_ON    (on),
    .ERR_CLR   (err_clr),
    .DO        (do_px),
    .DO_HLOCK  (hlock),
    .DO_VLOCK  (vlock),
    .DO_ACT    (act_o),
    .oERR      (oerr)
  );

  task automatic check(input string name, input int actual, input int required);
    checks++;
    if (actual != required) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, actual, required, $time);
    end
  endtask

  // Monitor: positions are counted from the output sync pulses themselves.
  int hpos = 0, vpos = 0, off_run = 2;
  bit synced = 1'b0;
  always @(negedge pck) begin
    if (!rstn) begin
      synced  = 1'b0;
      off_run = 2;
    end else begin
      if (on) off_run = 0;
      else if (off_run < 100) off_run++;
      if (vlock) begin
        hpos = 0; vpos = 0; synced = (off_run == 0);
      end else if (hlock) begin
        hpos = 0; vpos++;
      end else begin
        hpos++;
      end
      if (off_run >= 2) begin
        check("off_quiet", int'({hlock, vlock, act_o, do_px}), 0);
        synced = 1'b0;
      end else begin
        if (act_o) begin
          if (exp_q.size() == 0) check("pixel_unexpected", exp_q.size(), 1);
          else check("pixel", do_px, exp_q.pop_front());
          if (synced) begin
            check("act_hpos", int'(hpos >= Hsp && hpos < Hsp + Hw), 1);
            check("act_vpos", int'(vpos >= Vsp && vpos < Vsp + Vw), 1);
          end
        end else begin
          check("idle_do_zero", do_px, 0);
        end
        if (vlock) check("vlock_with_hlock", hlock, 1);
      end
    end
  end

  task automatic mrck_to(input int target);
    while (mcyc < target) begin
      @(posedge mrck);
      #1;
    end
  endtask

  // mode 0: output on all frame, 1: output off all frame, 2: output enabled after relock
  task automatic send_frame(input int mode, input int period, input bit special, input bit rst_mid);
    logic [7:0] y[Vw][Hw];
    int c0;
    bit seen;
    for (int l = 0; l < Vw; l++)
      for (int p = 0; p < Hw; p++) y[l][p] = 8'($urandom);
    if (special) begin
      y[1][0] = 8'hAA; y[1][1] = 8'hBB; y[1][2] = 8'hCC; y[1][3] = 8'hDD;
    end
    on = (mode == 0);
    if (mode != 1)
      for (int l = 0; l < Vw; l++)
        for (int p = 0; p < Hw; p++) exp_q.push_back({y[l][p], 2'b00});
    @(posedge mrck);
    #1;
    c0 = mcyc;
    vsync = 1'b1;
    if (mode == 0) begin
      seen = 1'b0;
      for (int i = 0; i < 12; i++) begin
        @(negedge pck);
        if (vlock) seen = 1'b1;
      end
      check("vlock_after_vsync", seen, 1);
    end
    mrck_to(c0 + 10);
    vsync = 1'b0;
    mrck_to(c0 + 50);
    if (mode == 2) on = 1'b1;
    for (int k = 0; k < Vw; k++) begin
      mrck_to(c0 + 200 + 100 * k);
      hsync = 1'b1;
      for (int w = 0; w < Hw / 4; w++) begin
        valid = 1'b1;
        data = {y[k][4*w], 8'h80, y[k][4*w+1], 8'h80, y[k][4*w+2], 8'h80, y[k][4*w+3], 8'h80};
        @(posedge mrck);
        #1;
      end
      valid = 1'b0;
      hsync = 1'b0;
      data  = '0;
    end
    if (rst_mid) begin
      seen = 1'b0;
      for (int i = 0; i < 400 && !seen; i++) begin
        @(negedge pck);
        seen = act_o;
      end
      check("rst_act_seen", seen, 1);
      repeat (5) @(posedge pck);
      #1 rstn = 1'b0;
      #1 check("rst_outputs", int'({do_px, hlock, vlock, act_o, oerr}), 0);
      on = 1'b0;
      exp_q.delete();
      repeat (3) @(posedge pck);
      #1 rstn = 1'b1;
    end
    mrck_to(c0 + period);
    check("frame_drained", exp_q.size(), 0);
  endtask

  task automatic send_line(input int n);
    @(posedge mrck);
    #1;
    for (int i = 0; i < n; i++) begin
      valid = 1'b1;
      data  = {$urandom, $urandom};
      @(posedge mrck);
      #1;
    end
    valid = 1'b0;
    data  = '0;
    repeat (4) @(posedge mrck);
  endtask

`ifdef MRX_ERR_EN
  localparam int ErrShort = 1, ErrLong = 3;
`else
  localparam int ErrShort = 0, ErrLong = 0;
`endif

  initial begin
    #400us;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge pck);
    #1;
    check("reset_do", do_px, 0);
    check("reset_flags", int'({hlock, vlock, act_o}), 0);
    check("reset_oerr", oerr, 0);
    rstn = 1'b1;

    send_frame(2, 900, 1'b0, 1'b0);
    send_frame(0, 880, 1'b1, 1'b0);
    for (int f = 0; f < 4; f++) send_frame(0, $urandom_range(760, 940), 1'b0, 1'b0);
    send_frame(1, 850, 1'b0, 1'b0);
    send_frame(0, 850, 1'b0, 1'b0);
    send_frame(0, 900, 1'b0, 1'b1);
    send_frame(2, 900, 1'b0, 1'b0);
    send_frame(0, 900, 1'b0, 1'b0);
    check("oerr_clean", oerr, 0);

    on = 1'b0;
    send_line(3);
    repeat (20) @(posedge pck);
    #1 check("oerr_short", oerr, ErrShort);
    send_line(MaxW + 1);
    repeat (20) @(posedge pck);
    #1 check("oerr_long", oerr, ErrLong);
    err_clr = 1'b1;
    repeat (3) @(posedge pck);
    #1 err_clr = 1'b0;
    repeat (3) @(posedge pck);
    #1 check("oerr_cleared", oerr, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
